// File: rtl/seg_display_mux.sv
// Time-multiplexed common-anode 7-segment driver: shadow/display double buffer,
// GAP/SHOW digit scan with dead time, hex decode, leading-zero blanking, decimal points.
module seg_display_mux #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_start
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
  localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_END = CW'(REFRESH_DIV - 1);

  typedef enum logic {GAP, SHOW} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
  logic [DIGITS-1:0]     sh_dp_q, sh_dp_d;
  logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic                  dp_n_q, dp_n_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic                  fs_q, fs_d;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit i>0 is a leading zero when it and every more significant nibble are zero.
  function automatic logic lz_blanked(input logic [4*DIGITS-1:0] d, input logic [IW-1:0] i);
    logic all_zero;
    all_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k >= 32'(i) && d[4*k +: 4] != 4'd0) all_zero = 1'b0;
    end
    return all_zero && (i != '0);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + CW'(1);
    sh_data_d   = load ? data  : sh_data_q;
    sh_dp_d     = load ? dp_in : sh_dp_q;
    disp_data_d = disp_data_q;
    disp_dp_d   = disp_dp_q;
    fs_d        = 1'b0;
    case (state_q)
      GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
          if (idx_d == '0) begin
            // Frame boundary: take shadow including a load on this same edge.
            disp_data_d = sh_data_d;
            disp_dp_d   = sh_dp_d;
            fs_d        = 1'b1;
          end
        end
      end
      default: begin
        if (cnt_q == SHOW_END) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Outputs are derived from next-state values so they register in step with the scan.
  always_comb begin
    seg_n_d = '1;
    dp_n_d  = 1'b1;
    an_n_d  = '1;
    if (state_d == SHOW) begin
      an_n_d = ~(DIGITS'(1) << idx_d);
      dp_n_d = ~disp_dp_d[idx_d];
      if (!(blank_lz && lz_blanked(disp_data_d, idx_d)))
        seg_n_d = ~decode(disp_data_d[{idx_d, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GAP;
      idx_q       <= LAST_IDX;
      cnt_q       <= '0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      seg_n_q     <= '1;
      dp_n_q      <= 1'b1;
      an_n_q      <= '1;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      an_n_q      <= an_n_d;
      fs_q        <= fs_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: directed scenarios then random loads/blanking/resets,
// checked every cycle against a frame-position reference model.
module tb_seg_display_mux;

  localparam int D = 4;
  localparam int R = 4;
  localparam int G = 1;
  localparam int SLOT  = R + G;
  localparam int FRAME = D * SLOT;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  int tests = 0;
  int failed = 0;

  // Reference model: k = edges since reset release (0 = in reset state).
  int          k = 0;
  logic [15:0] m_sh = '0, m_disp = '0;
  logic [3:0]  m_shdp = '0, m_dispdp = '0;
  bit          m_show;
  int          m_dig;

  seg_display_mux #(.DIGITS(D), .REFRESH_DIV(R), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic step();
    logic [6:0] e_seg;
    logic       e_dp, e_fs;
    logic [3:0] e_an;
    int         q;
    if (rst) begin
      k = 0; m_sh = '0; m_shdp = '0; m_disp = '0; m_dispdp = '0;
    end else begin
      k++;
      if (load) begin m_sh = data; m_shdp = dp_in; end
      if ((k - 1) % FRAME == 0) begin m_disp = m_sh; m_dispdp = m_shdp; end
    end
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fs = 1'b0; m_show = 0; m_dig = 0;
    if (k > 0) begin
      q      = (k - 1) % FRAME;
      m_dig  = q / SLOT;
      m_show = (q % SLOT) < R;
      e_fs   = (q == 0);
      if (m_show) begin
        e_an = 4'hF & ~(4'h1 << m_dig);
        e_dp = ~m_dispdp[m_dig];
        if (!(blank_lz && m_dig > 0 && (m_disp >> (4 * m_dig)) == 16'h0))
          e_seg = ~SEG[(m_disp >> (4 * m_dig)) & 16'hF];
      end
    end
    @(posedge clk);
    #1;
    check("an_n", 32'(an_n), 32'(e_an));
    check("seg_n", 32'(seg_n), 32'(e_seg));
    check("dp_n", 32'(dp_n), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("one_hot_an", 32'($countones(~an_n) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model is lighting digit d (bounded).
  task automatic run_to_digit(input int d);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_show && m_dig == d) break;
      step();
    end
    check("reach_digit", 32'(m_show && m_dig == d), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(FRAME);

    data = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    run(2 * FRAME);

    run_to_digit(2);
    data = 16'h3456; dp_in = 4'b1001; load = 1'b1;
    step();
    load = 1'b0;
    run(2 * FRAME);

    // Back-to-back loads: last one wins.
    data = 16'hBEEF; load = 1'b1; step();
    data = 16'h0050; dp_in = 4'b0000; step();
    load = 1'b0; blank_lz = 1'b1;
    run(2 * FRAME);
    data = 16'h0000; load = 1'b1; step();
    load = 1'b0;
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(FRAME);

    data = 16'h9C7D; dp_in = 4'b1111; load = 1'b1; step();
    load = 1'b0;
    run(FRAME);
    run_to_digit(2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(FRAME + 5);

    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      data  = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      rst   = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
